// File: rtl/cmd_types_pkg.sv
// Shared types, FSM states and response codes for the command dispatcher.
package cmd_types_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DISPATCH,
        RESPOND
    } cmd_disp_state_t;

    localparam byte_t RESP_ACK          = 8'hAC;
    localparam byte_t RESP_NACK_UNKNOWN = 8'hE1;
    localparam byte_t RESP_NACK_TIMEOUT = 8'hE2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cmd_opcode_lookup.sv
// Combinational opcode table match; lowest table index wins on duplicates.
module cmd_opcode_lookup
    import cmd_types_pkg::*;
#(
    parameter int    N_CMDS              = 4,
    parameter int    IDX_W               = 2,
    parameter int    LEN_W               = 6,
    parameter byte_t CMD_OPCODES [N_CMDS] = '{8'hA0, 8'hA1, 8'hB0, 8'hC0},
    parameter int    CMD_LENGTHS [N_CMDS] = '{1, 24, 20, 0}
) (
    input  byte_t            opcode,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic [LEN_W-1:0] len
);

    // Scan from the top so the lowest matching entry is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        len = '0;
        for (int i = N_CMDS - 1; i >= 0; i--) begin
            if (opcode == CMD_OPCODES[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
                len = LEN_W'(CMD_LENGTHS[i]);
            end
        end
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// Table-driven command front end: opcode match, payload collection,
// wide-word dispatch and ACK/NACK response with stall timeout.
module cmd_dispatcher
    import cmd_types_pkg::*;
#(
    parameter int    N_CMDS              = 4,
    parameter int    MAX_PAYLOAD_BYTES   = 32,
    parameter byte_t CMD_OPCODES [N_CMDS] = '{8'hA0, 8'hA1, 8'hB0, 8'hC0},
    parameter int    CMD_LENGTHS [N_CMDS] = '{1, 24, 20, 0},
    parameter int    TIMEOUT_CYCLES      = 1_000_000,
    parameter bit    RESP_ENABLE         = 1'b1,
    localparam int   IDX_W = (N_CMDS > 1) ? $clog2(N_CMDS) : 1,
    localparam int   PL_W  = 8 * MAX_PAYLOAD_BYTES
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_in_valid,
    output logic             cmd_in_ready,
    input  logic [7:0]       cmd_in_data,
    output logic             cmd_out_valid,
    input  logic             cmd_out_ready,
    output logic [7:0]       cmd_out_data,
    output logic             pl_valid,
    input  logic             pl_ready,
    output logic [IDX_W-1:0] pl_cmd_idx,
    output logic [PL_W-1:0]  pl_data,
    output logic [15:0]      err_unknown,
    output logic [15:0]      err_timeout
);

    localparam int CNT_W = $clog2(MAX_PAYLOAD_BYTES + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    if (N_CMDS < 1) begin : g_bad_n
        $error("cmd_dispatcher: N_CMDS must be at least 1");
    end

    for (genvar g = 0; g < N_CMDS; g++) begin : g_len_chk
        if (CMD_LENGTHS[g] > MAX_PAYLOAD_BYTES) begin : g_bad_len
            $error("cmd_dispatcher: CMD_LENGTHS entry exceeds MAX_PAYLOAD_BYTES");
        end
    end

    cmd_disp_state_t  state;
    logic [CNT_W-1:0] remain;
    logic [TO_W-1:0]  idle_cnt;
    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic [CNT_W-1:0] lk_len;
    logic             in_fire;
    logic             to_hit;
    logic [PL_W-1:0]  pl_shift;

    cmd_opcode_lookup #(
        .N_CMDS      (N_CMDS),
        .IDX_W       (IDX_W),
        .LEN_W       (CNT_W),
        .CMD_OPCODES (CMD_OPCODES),
        .CMD_LENGTHS (CMD_LENGTHS)
    ) u_lookup (
        .opcode (cmd_in_data),
        .hit    (lk_hit),
        .idx    (lk_idx),
        .len    (lk_len)
    );

    assign in_fire  = cmd_in_valid & cmd_in_ready;
    assign to_hit   = TO_EN && (idle_cnt == TO_MAX);
    assign pl_shift = (pl_data << 8) | PL_W'(cmd_in_data);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cmd_in_ready  <= 1'b0;
            cmd_out_valid <= 1'b0;
            cmd_out_data  <= '0;
            pl_valid      <= 1'b0;
            pl_cmd_idx    <= '0;
            pl_data       <= '0;
            err_unknown   <= '0;
            err_timeout   <= '0;
            remain        <= '0;
            idle_cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_in_ready <= 1'b1;
                    if (in_fire) begin
                        pl_data  <= '0;
                        remain   <= lk_len;
                        idle_cnt <= '0;
                        if (lk_hit) begin
                            pl_cmd_idx <= lk_idx;
                            if (lk_len != '0) begin
                                state <= PAYLOAD;
                            end else begin
                                state        <= DISPATCH;
                                pl_valid     <= 1'b1;
                                cmd_in_ready <= 1'b0;
                            end
                        end else begin
                            err_unknown <= sat_inc16(err_unknown);
                            if (RESP_ENABLE) begin
                                state         <= RESPOND;
                                cmd_out_valid <= 1'b1;
                                cmd_out_data  <= RESP_NACK_UNKNOWN;
                                cmd_in_ready  <= 1'b0;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    // An accepted byte always beats an expiring timer.
                    if (in_fire) begin
                        pl_data  <= pl_shift;
                        remain   <= remain - CNT_W'(1);
                        idle_cnt <= '0;
                        if (remain == CNT_W'(1)) begin
                            state        <= DISPATCH;
                            pl_valid     <= 1'b1;
                            cmd_in_ready <= 1'b0;
                        end
                    end else if (to_hit) begin
                        pl_data     <= '0;
                        idle_cnt    <= '0;
                        err_timeout <= sat_inc16(err_timeout);
                        if (RESP_ENABLE) begin
                            state         <= RESPOND;
                            cmd_out_valid <= 1'b1;
                            cmd_out_data  <= RESP_NACK_TIMEOUT;
                            cmd_in_ready  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
                DISPATCH: begin
                    if (pl_ready) begin
                        pl_valid <= 1'b0;
                        if (RESP_ENABLE) begin
                            state         <= RESPOND;
                            cmd_out_valid <= 1'b1;
                            cmd_out_data  <= RESP_ACK;
                        end else begin
                            state        <= IDLE;
                            cmd_in_ready <= 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    if (cmd_out_ready) begin
                        state         <= IDLE;
                        cmd_out_valid <= 1'b0;
                        cmd_in_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench: directed scenarios plus random byte stream against
// a transaction-level reference model checked on every cycle.
module tb_cmd_dispatcher;

    localparam int NC   = 4;
    localparam int MAXB = 32;
    localparam int TO   = 16;
    localparam logic [7:0] OPC [NC] = '{8'hA0, 8'hA1, 8'hB0, 8'hC0};
    localparam int         LEN [NC] = '{1, 24, 20, 0};

    logic         clk = 1'b0;
    logic         rstn;
    logic         cmd_in_valid;
    logic         cmd_in_ready;
    logic [7:0]   cmd_in_data;
    logic         cmd_out_valid;
    logic         cmd_out_ready;
    logic [7:0]   cmd_out_data;
    logic         pl_valid;
    logic         pl_ready;
    logic [1:0]   pl_cmd_idx;
    logic [255:0] pl_data;
    logic [15:0]  err_unknown;
    logic [15:0]  err_timeout;

    int checks = 0;
    int errors = 0;
    bit rand_mode;
    bit last_fire;

    bit           m_armed, m_plv, m_outv, m_coll;
    int           m_idx, m_cur, m_idle, m_eu, m_et;
    logic [7:0]   m_out;
    logic [255:0] m_pl;
    logic [7:0]   m_bytes [$];

    always #5 clk = ~clk;

    cmd_dispatcher #(
        .N_CMDS            (NC),
        .MAX_PAYLOAD_BYTES (MAXB),
        .CMD_OPCODES       (OPC),
        .CMD_LENGTHS       (LEN),
        .TIMEOUT_CYCLES    (TO),
        .RESP_ENABLE       (1'b1)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cmd_in_valid  (cmd_in_valid),
        .cmd_in_ready  (cmd_in_ready),
        .cmd_in_data   (cmd_in_data),
        .cmd_out_valid (cmd_out_valid),
        .cmd_out_ready (cmd_out_ready),
        .cmd_out_data  (cmd_out_data),
        .pl_valid      (pl_valid),
        .pl_ready      (pl_ready),
        .pl_cmd_idx    (pl_cmd_idx),
        .pl_data       (pl_data),
        .err_unknown   (err_unknown),
        .err_timeout   (err_timeout)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [255:0] got,
                        input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int find_op(input logic [7:0] b);
        for (int i = 0; i < NC; i++)
            if (OPC[i] == b) return i;
        return -1;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_plv = 0; m_outv = 0; m_coll = 0;
        m_idx = 0; m_cur = 0; m_idle = 0; m_eu = 0; m_et = 0;
        m_out = '0; m_pl = '0;
        m_bytes.delete();
    endtask

    // Check outputs for the current cycle, then advance the model
    // to what must hold after the coming clock edge.
    task automatic model_step();
        bit rdy, fire, plf, outf;
        int k;
        if (!rstn) begin
            chk("rst_in_ready", int'(cmd_in_ready), 0);
            chk("rst_pl_valid", int'(pl_valid), 0);
            chk("rst_pl_idx", int'(pl_cmd_idx), 0);
            chkw("rst_pl_data", pl_data, '0);
            chk("rst_out_valid", int'(cmd_out_valid), 0);
            chk("rst_out_data", int'(cmd_out_data), 0);
            chk("rst_err_unk", int'(err_unknown), 0);
            chk("rst_err_to", int'(err_timeout), 0);
            model_reset();
            last_fire = 0;
            return;
        end
        rdy = m_armed && !m_plv && !m_outv;
        chk("in_ready", int'(cmd_in_ready), int'(rdy));
        chk("pl_valid", int'(pl_valid), int'(m_plv));
        if (m_plv) begin
            chk("pl_idx", int'(pl_cmd_idx), m_idx);
            chkw("pl_data", pl_data, m_pl);
        end
        chk("out_valid", int'(cmd_out_valid), int'(m_outv));
        if (m_outv) chk("out_data", int'(cmd_out_data), int'(m_out));
        chk("err_unk", int'(err_unknown), m_eu);
        chk("err_to", int'(err_timeout), m_et);

        fire = rdy && cmd_in_valid;
        plf  = m_plv && pl_ready;
        outf = m_outv && cmd_out_ready;
        last_fire = fire;
        m_armed = 1;
        if (plf) begin
            m_plv = 0; m_outv = 1; m_out = 8'hAC;
        end
        if (outf) m_outv = 0;
        if (fire && !m_coll) begin
            k = find_op(cmd_in_data);
            if (k < 0) begin
                m_eu = sat(m_eu); m_outv = 1; m_out = 8'hE1;
            end else if (LEN[k] == 0) begin
                m_plv = 1; m_idx = k; m_pl = '0;
            end else begin
                m_coll = 1; m_cur = k; m_idle = 0;
                m_bytes.delete();
            end
        end else if (fire) begin
            m_bytes.push_back(cmd_in_data);
            m_idle = 0;
            if (m_bytes.size() == LEN[m_cur]) begin
                m_coll = 0; m_plv = 1; m_idx = m_cur; m_pl = '0;
                foreach (m_bytes[j])
                    m_pl[(LEN[m_cur] - 1 - j) * 8 +: 8] = m_bytes[j];
            end
        end else if (m_coll) begin
            if (m_idle == TO) begin
                m_coll = 0; m_et = sat(m_et); m_outv = 1; m_out = 8'hE2;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            pl_ready      = ($urandom_range(3) != 0);
            cmd_out_ready = ($urandom_range(3) != 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_in_valid = 1'b1;
        cmd_in_data  = b;
        do begin
            tick();
            n++;
        end while (!last_fire && n < 400);
        if (!last_fire) begin
            checks++;
            errors++;
            $display("FAIL send_stall got=no_accept exp=accept byte=%0h", b);
        end
        cmd_in_valid = 1'b0;
    endtask

    initial begin
        int r;
        logic [7:0] b;
        rstn = 1'b0; cmd_in_valid = 1'b0; cmd_in_data = '0;
        pl_ready = 1'b1; cmd_out_ready = 1'b1; rand_mode = 0; last_fire = 0;
        model_reset();
        repeat (3) tick();
        rstn = 1'b1;
        chk("rel_ready_low", int'(cmd_in_ready), 0);
        tick();
        chk("rel_ready_high", int'(cmd_in_ready), 1);

        // A1 with 24 bytes
        send_byte(8'hA1);
        for (int i = 1; i <= 24; i++) send_byte(8'(i));
        chk("t1_pl_valid", int'(pl_valid), 1);
        chk("t1_idx", int'(pl_cmd_idx), 1);
        chkw("t1_data", pl_data, 256'h0102030405060708090a0b0c0d0e0f101112131415161718);
        tick();
        chk("t1_ack_valid", int'(cmd_out_valid), 1);
        chk("t1_ack", int'(cmd_out_data), 'hAC);
        tick();

        // Zero-length C0
        send_byte(8'hC0);
        chk("t2_pl_valid", int'(pl_valid), 1);
        chk("t2_idx", int'(pl_cmd_idx), 3);
        chkw("t2_data", pl_data, '0);
        tick();
        chk("t2_ack", int'(cmd_out_data), 'hAC);
        tick();

        // Unknown opcode then a normal A0
        send_byte(8'h55);
        chk("t3_pl_valid", int'(pl_valid), 0);
        chk("t3_nack_valid", int'(cmd_out_valid), 1);
        chk("t3_nack", int'(cmd_out_data), 'hE1);
        chk("t3_err_unk", int'(err_unknown), 1);
        send_byte(8'hA0);
        send_byte(8'h01);
        chk("t3_idx", int'(pl_cmd_idx), 0);
        chkw("t3_data", pl_data, 256'h01);
        tick();

        // Timeout after B0 + 5 bytes
        send_byte(8'hB0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i));
        repeat (TO) tick();
        chk("t4_no_resp_yet", int'(cmd_out_valid), 0);
        tick();
        chk("t4_to_valid", int'(cmd_out_valid), 1);
        chk("t4_to_code", int'(cmd_out_data), 'hE2);
        chk("t4_err_to", int'(err_timeout), 1);
        tick();
        // Byte arriving in the expiry cycle is kept
        send_byte(8'hB0);
        send_byte(8'h77);
        send_byte(8'h66);
        repeat (TO) tick();
        for (int i = 0; i < 18; i++) send_byte(8'(8'h40 + i));
        chk("t4_pl_valid", int'(pl_valid), 1);
        chk("t4_idx", int'(pl_cmd_idx), 2);
        chk("t4_err_to_kept", int'(err_timeout), 1);
        tick();
        tick();

        // Backpressure from both consumers
        pl_ready = 1'b0;
        send_byte(8'hA0);
        send_byte(8'h5A);
        cmd_in_valid = 1'b1;
        cmd_in_data  = 8'hC0;
        repeat (10) tick();
        chk("t5_pl_hold", int'(pl_valid), 1);
        chkw("t5_data_hold", pl_data, 256'h5A);
        pl_ready = 1'b1;
        cmd_out_ready = 1'b0;
        tick();
        chk("t5_pl_done", int'(pl_valid), 0);
        repeat (5) tick();
        chk("t5_out_hold", int'(cmd_out_valid), 1);
        chk("t5_in_blocked", int'(cmd_in_ready), 0);
        cmd_out_ready = 1'b1;
        send_byte(8'hC0);
        chk("t5_c0_idx", int'(pl_cmd_idx), 3);
        tick();
        tick();

        // Reset in the middle of a payload
        send_byte(8'hA1);
        for (int i = 0; i < 10; i++) send_byte(8'(8'hF0 + i));
        rstn = 1'b0;
        #1;
        chk("t6_rst_ready", int'(cmd_in_ready), 0);
        chk("t6_rst_err_to", int'(err_timeout), 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        send_byte(8'hA1);
        for (int i = 1; i <= 24; i++) send_byte(8'(i));
        chkw("t6_data", pl_data, 256'h0102030405060708090a0b0c0d0e0f101112131415161718);
        tick();
        tick();

        // Random stream with random consumer backpressure
        rand_mode = 1;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(99));
            if (r < 30) b = OPC[$urandom_range(NC - 1)];
            else b = 8'($urandom);
            send_byte(b);
            r = int'($urandom_range(99));
            if (r >= 96) repeat (TO + $urandom_range(4)) tick();
            else if (r >= 85) repeat (1 + $urandom_range(2)) tick();
        end
        rand_mode = 0;
        pl_ready = 1'b1;
        cmd_out_ready = 1'b1;
        repeat (40) tick();
        chk("drain_ready", int'(cmd_in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
